// File: rtl/system_controller_pkg.sv
// -----------------------------------------------------------------------------
// system_controller_pkg
//
// Purpose:
//   Shared definitions for the reset sequencer: the sequencing FSM state type
//   with its fixed encodings, and a helper that sizes the internal counters.
//
// Contents:
//   state_e        - ST_ASSERT (2'b00), ST_RELEASE (2'b01), ST_RUN (2'b10).
//                    2'b11 is never produced and is recovered to ST_ASSERT.
//   counter_width  - bit width needed to count 0..max(a,b,c)-1, minimum 1.
// -----------------------------------------------------------------------------
package system_controller_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'b00,
    ST_RELEASE = 2'b01,
    ST_RUN     = 2'b10
  } state_e;

  // One shared width for the hold, stagger and divider counters. A terminal
  // count of m-1 needs $clog2(m) bits; m of 1 or 2 still needs a single bit.
  function automatic int unsigned counter_width(input int unsigned a,
                                                input int unsigned b,
                                                input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (m < 2) return 1;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/clk_en_divider.sv
// -----------------------------------------------------------------------------
// clk_en_divider
//
// Purpose:
//   Produces a registered one-cycle enable pulse every DIV clock cycles while
//   ENABLE is high. With DIV=1 the pulse is high on every enabled cycle.
//
// Ports:
//   CLK_IN      in  1  clock
//   RESET_IN    in  1  synchronous active-high reset (clears count and pulse)
//   ENABLE      in  1  count while high
//   CLK_EN_OUT  out 1  registered enable pulse
//
// The first pulse appears DIV enabled edges after the counter leaves reset.
// -----------------------------------------------------------------------------
module clk_en_divider
  import system_controller_pkg::*;
#(
  parameter int unsigned DIV   = 4,
  parameter int unsigned CNT_W = counter_width(DIV, 1, 1)
) (
  input  logic CLK_IN,
  input  logic RESET_IN,
  input  logic ENABLE,
  output logic CLK_EN_OUT
);

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] div_cnt_q;
  logic [CNT_W-1:0] div_cnt_d;
  logic             en_q;
  logic             en_d;

  always_comb begin
    div_cnt_d = div_cnt_q;
    en_d      = 1'b0;
    if (ENABLE) begin
      if (div_cnt_q == DIV_LAST) begin
        // Wrap and pulse; with DIV=1 this branch fires on every edge.
        div_cnt_d = '0;
        en_d      = 1'b1;
      end else begin
        div_cnt_d = div_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK_IN) begin
    if (RESET_IN) begin
      div_cnt_q <= '0;
      en_q      <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      en_q      <= en_d;
    end
  end

  assign CLK_EN_OUT = en_q;

endmodule

// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//
// Purpose:
//   Generates CHANNELS staggered, sequenced active-high reset outputs from a
//   single clock and reset, plus a divided clock-enable tick once every
//   channel has been released. A software reset request replays the whole
//   sequence.
//
// Ports:
//   CLK_IN         in  1         system clock (only clock)
//   RESET_IN       in  1         synchronous active-high reset
//   SOFT_RESET_IN  in  1         software reset request, sampled every edge
//   CLK_OUT        out 1         pass-through of CLK_IN
//   RESET_OUT      out CHANNELS  per-channel reset, registered, active-high
//   READY_OUT      out 1         high once all channels are released
//   CLK_EN_OUT     out 1         enable pulse every DIV cycles while in RUN
//   STATE_OUT      out 2         current FSM state
//
// Sequence, counting edges from the first one that samples both reset
// sources low as edge 1:
//   RESET_OUT[i] falls after edge HOLD_CYCLES + i*STAGGER_CYCLES,
//   READY_OUT rises together with the last channel release,
//   CLK_EN_OUT first pulses DIV edges after READY_OUT rises.
// -----------------------------------------------------------------------------
module reset_sequencer
  import system_controller_pkg::*;
#(
  parameter int unsigned CHANNELS       = 4,
  parameter int unsigned HOLD_CYCLES    = 16,
  parameter int unsigned STAGGER_CYCLES = 8,
  parameter int unsigned DIV            = 4
) (
  input  logic                CLK_IN,
  input  logic                RESET_IN,
  input  logic                SOFT_RESET_IN,
  output logic                CLK_OUT,
  output logic [CHANNELS-1:0] RESET_OUT,
  output logic                READY_OUT,
  output logic                CLK_EN_OUT,
  output logic [1:0]          STATE_OUT
);

  localparam int unsigned CNT_W = counter_width(HOLD_CYCLES, STAGGER_CYCLES, DIV);
  localparam int unsigned IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(CHANNELS - 1);

  state_e                state_q;
  state_e                state_d;
  logic [CNT_W-1:0]      seq_cnt_q;
  logic [CNT_W-1:0]      seq_cnt_d;
  logic [IDX_W-1:0]      chan_idx_q;
  logic [IDX_W-1:0]      chan_idx_d;
  logic [CHANNELS-1:0]   rst_out_q;
  logic [CHANNELS-1:0]   rst_out_d;
  logic                  ready_q;
  logic                  ready_d;

  // release_fire: the channel addressed by chan_idx_q is released this edge.
  // restart: every channel returns to reset and the sequence starts over.
  logic                  release_fire;
  logic                  restart;
  logic [CHANNELS-1:0]   clear_mask;

  logic                  div_reset;
  logic                  div_enable;

  // ---------------------------------------------------------------------------
  // Next-state logic: FSM, hold/stagger counter and channel index.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    seq_cnt_d    = seq_cnt_q;
    chan_idx_d   = chan_idx_q;
    ready_d      = ready_q;
    release_fire = 1'b0;
    restart      = 1'b0;

    if (SOFT_RESET_IN) begin
      // The hold count only starts on the first edge that samples the
      // request low, so holding it high parks the block in ASSERT.
      restart    = 1'b1;
      state_d    = ST_ASSERT;
      seq_cnt_d  = '0;
      chan_idx_d = '0;
      ready_d    = 1'b0;
    end else begin
      unique case (state_q)
        ST_ASSERT: begin
          if (seq_cnt_q == HOLD_LAST) begin
            // Last hold cycle releases channel 0 (chan_idx_q is 0 here).
            seq_cnt_d    = '0;
            release_fire = 1'b1;
            if (CHANNELS > 1) begin
              state_d    = ST_RELEASE;
              chan_idx_d = IDX_W'(1);
            end else begin
              state_d = ST_RUN;
              ready_d = 1'b1;
            end
          end else begin
            seq_cnt_d = seq_cnt_q + CNT_W'(1);
          end
        end

        ST_RELEASE: begin
          if (seq_cnt_q == STAGGER_LAST) begin
            seq_cnt_d    = '0;
            release_fire = 1'b1;
            if (chan_idx_q == LAST_IDX) begin
              // Final channel: READY rises on the same edge it is released.
              state_d = ST_RUN;
              ready_d = 1'b1;
            end else begin
              chan_idx_d = chan_idx_q + IDX_W'(1);
            end
          end else begin
            seq_cnt_d = seq_cnt_q + CNT_W'(1);
          end
        end

        ST_RUN: begin
          // Sequencing is complete; only the divider is active.
        end

        default: begin
          // Unused encoding 2'b11: recover by replaying the full sequence.
          restart    = 1'b1;
          state_d    = ST_ASSERT;
          seq_cnt_d  = '0;
          chan_idx_d = '0;
          ready_d    = 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel release mask. Bits are only ever cleared here, so a released
  // channel stays released until a restart or RESET_IN.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_clear
    assign clear_mask[gi] = release_fire && (chan_idx_q == IDX_W'(gi));
  end

  assign rst_out_d = restart ? {CHANNELS{1'b1}} : (rst_out_q & ~clear_mask);

  // ---------------------------------------------------------------------------
  // State registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK_IN) begin
    if (RESET_IN) begin
      state_q    <= ST_ASSERT;
      seq_cnt_q  <= '0;
      chan_idx_q <= '0;
      rst_out_q  <= {CHANNELS{1'b1}};
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      seq_cnt_q  <= seq_cnt_d;
      chan_idx_q <= chan_idx_d;
      rst_out_q  <= rst_out_d;
      ready_q    <= ready_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Clock-enable divider. It is held in reset outside RUN, so its count is
  // aligned to the edge that entered RUN; a soft request clears the pulse on
  // the same edge that re-asserts the channels.
  // ---------------------------------------------------------------------------
  assign div_enable = (state_q == ST_RUN);
  assign div_reset  = RESET_IN | SOFT_RESET_IN | ~div_enable;

  clk_en_divider #(
    .DIV   (DIV),
    .CNT_W (CNT_W)
  ) u_clk_en_divider (
    .CLK_IN     (CLK_IN),
    .RESET_IN   (div_reset),
    .ENABLE     (div_enable),
    .CLK_EN_OUT (CLK_EN_OUT)
  );

  assign CLK_OUT   = CLK_IN;
  assign RESET_OUT = rst_out_q;
  assign READY_OUT = ready_q;
  assign STATE_OUT = state_q;

endmodule
